// File: rtl/mem_access_splitter.sv
// Memory-stage front end: passes aligned loads/stores straight to the data memory and
// splits misaligned ones into byte accesses while stalling. Optional macro MEM_MISALIGN_TRAP_EN.
module mem_access_splitter #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic [63:0] dm_address,
    output logic        dm_write_enable,
    output logic        dm_read_enable,
    output logic [63:0] dm_write_data,
    output logic [3:0]  dm_xfer_size,
    input  logic [63:0] dm_read_data,
    output logic        stall,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        misalign_err,
    output logic        range_err
);

`ifdef MEM_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [2:0]  cnt_r;
    logic [63:0] lat_addr_r;
    logic [63:0] lat_wdata_r;
    logic [3:0]  lat_size_r;
    logic        lat_write_r;
    logic [63:0] assembly_r;

    logic [64:0] end_addr_s;
    logic        range_bad_s;
    logic        misaligned_s;
    logic        start_split_s;
    logic        last_byte_s;
    logic [63:0] merged_s;

    function automatic logic size_legal(input logic [3:0] size);
        logic ok;
        case (size)
            4'd1, 4'd2, 4'd4, 4'd8: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [63:0] size_mask(input logic [3:0] size);
        logic [63:0] m;
        case (size)
            4'd1:    m = 64'h0000_0000_0000_00FF;
            4'd2:    m = 64'h0000_0000_0000_FFFF;
            4'd4:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Request classification and byte-merge helpers; 65-bit sum so huge addresses cannot wrap past the check
    always_comb begin
        end_addr_s   = {1'b0, req_addr} + {61'd0, req_size};
        range_bad_s  = !size_legal(req_size) || (end_addr_s > 65'(MEM_BYTES));
        misaligned_s = (req_addr & ({60'd0, req_size} - 64'd1)) != 64'd0;
        last_byte_s  = ({1'b0, cnt_r} == (lat_size_r - 4'd1));
        merged_s     = assembly_r;
        merged_s[{cnt_r, 3'b000} +: 8] = dm_read_data[7:0];
    end

    // Next-state and all data-memory / response outputs
    always_comb begin
        state_nx_s      = state_r;
        start_split_s   = 1'b0;
        dm_address      = 64'd0;
        dm_write_enable = 1'b0;
        dm_read_enable  = 1'b0;
        dm_write_data   = 64'd0;
        dm_xfer_size    = 4'd8;
        stall           = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = 64'd0;
        misalign_err    = 1'b0;
        range_err       = 1'b0;
        if (reset) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!req_valid) begin
                        state_nx_s = ST_IDLE;
                    end else if (range_bad_s) begin
                        range_err = 1'b1;
                    end else if (misaligned_s && TRAP_EN) begin
                        misalign_err = 1'b1;
                    end else if (misaligned_s) begin
                        dm_address      = req_addr;
                        dm_xfer_size    = 4'd1;
                        dm_write_data   = {56'd0, req_wdata[7:0]};
                        dm_write_enable = req_write;
                        dm_read_enable  = !req_write;
                        stall           = 1'b1;
                        start_split_s   = 1'b1;
                        state_nx_s      = ST_SPLIT;
                    end else begin
                        dm_address      = req_addr;
                        dm_xfer_size    = req_size;
                        dm_write_data   = req_wdata;
                        dm_write_enable = req_write;
                        dm_read_enable  = !req_write;
                        resp_valid      = !req_write;
                        resp_rdata      = req_write ? 64'd0 : (dm_read_data & size_mask(req_size));
                    end
                end
                ST_SPLIT: begin
                    dm_address      = lat_addr_r + {61'd0, cnt_r};
                    dm_xfer_size    = 4'd1;
                    dm_write_data   = {56'd0, lat_wdata_r[{cnt_r, 3'b000} +: 8]};
                    dm_write_enable = lat_write_r;
                    dm_read_enable  = !lat_write_r;
                    if (last_byte_s) begin
                        resp_valid = !lat_write_r;
                        resp_rdata = lat_write_r ? 64'd0 : (merged_s & size_mask(lat_size_r));
                        state_nx_s = ST_IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, byte counter, latched request and read-byte assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            lat_addr_r  <= 64'd0;
            lat_wdata_r <= 64'd0;
            lat_size_r  <= 4'd0;
            lat_write_r <= 1'b0;
            assembly_r  <= 64'd0;
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                ST_IDLE: begin
                    if (start_split_s) begin
                        lat_addr_r  <= req_addr;
                        lat_wdata_r <= req_wdata;
                        lat_size_r  <= req_size;
                        lat_write_r <= req_write;
                        cnt_r       <= 3'd1;
                        assembly_r  <= {56'd0, dm_read_data[7:0]};
                    end
                end
                ST_SPLIT: begin
                    if (state_nx_s == ST_IDLE) begin
                        cnt_r <= 3'd0;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                    if (!lat_write_r) begin
                        assembly_r[{cnt_r, 3'b000} +: 8] <= dm_read_data[7:0];
                    end
                end
                default: begin
                    cnt_r <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_splitter.sv
// Randomised and directed bench for mem_access_splitter against a byte-array memory
// and a reference model computed from the access rules (alignment, range, byte order).
module tb_mem_access_splitter;

    localparam int MEM = 1024;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [3:0]  req_size;
    logic [63:0] dm_address, dm_write_data, dm_read_data, resp_rdata;
    logic        dm_write_enable, dm_read_enable, stall, resp_valid, misalign_err, range_err;
    logic [3:0]  dm_xfer_size;

    logic [7:0] mem     [MEM];
    logic [7:0] ref_mem [MEM];
    int vectors = 0;
    int miscompares = 0;

    mem_access_splitter #(.MEM_BYTES(MEM)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .dm_address(dm_address), .dm_write_enable(dm_write_enable),
        .dm_read_enable(dm_read_enable), .dm_write_data(dm_write_data),
        .dm_xfer_size(dm_xfer_size), .dm_read_data(dm_read_data),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .misalign_err(misalign_err), .range_err(range_err)
    );

    always #5 clk = ~clk;

    // Data memory: combinational little-endian read, write on the clock edge
    always_comb begin
        dm_read_data = 64'd0;
        if (dm_read_enable) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(dm_xfer_size)) dm_read_data[8*i +: 8] = mem[int'((dm_address + 64'(i)) % 64'(MEM))];
            end
        end
    end

    always @(posedge clk) begin
        if (dm_write_enable) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(dm_xfer_size)) mem[int'((dm_address + 64'(i)) % 64'(MEM))] <= dm_write_data[8*i +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request from idle; returns the response data seen (0 if none)
    task automatic run_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                           input logic [3:0] s, output logic [63:0] got);
        bit legal_size, exp_range, exp_mis, exp_trap;
        int exp_cyc, cyc, acc, resps;
        logic [63:0] exp_rd;
        logic first_range, first_trap;
        logic [3:0] first_xfer;
        legal_size = (s == 4'd1) || (s == 4'd2) || (s == 4'd4) || (s == 4'd8);
        exp_range  = !legal_size || (a > 64'(MEM - int'(s)));
        exp_mis    = !exp_range && ((a % 64'(s)) != 64'd0);
        exp_trap   = TRAP && exp_mis;
        exp_cyc    = (exp_mis && !TRAP) ? int'(s) : 1;
        exp_rd     = 64'd0;
        if (!exp_range) for (int i = 0; i < int'(s); i++) exp_rd[8*i +: 8] = ref_mem[int'(a) + i];
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_size = s;
        cyc = 0; acc = 0; resps = 0; got = 64'd0;
        first_range = 1'b0; first_trap = 1'b0; first_xfer = 4'd0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                first_range = range_err; first_trap = misalign_err; first_xfer = dm_xfer_size;
            end
            cyc++;
            if (dm_read_enable || dm_write_enable) acc++;
            if (resp_valid) begin resps++; got = resp_rdata; end
            if (!stall) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("range_err", 64'(first_range), 64'(exp_range));
        check("misalign_err", 64'(first_trap), 64'(exp_trap));
        check("cycles", 64'(cyc), 64'(exp_cyc));
        check("dm_accesses", 64'(acc), (exp_range || exp_trap) ? 64'd0 : 64'(exp_cyc));
        check("resp_count", 64'(resps), (!w && !exp_range && !exp_trap) ? 64'd1 : 64'd0);
        if (!exp_range && !exp_trap) begin
            check("xfer_size", 64'(first_xfer), exp_mis ? 64'd1 : 64'(s));
            if (!w) check("rdata", got, exp_rd);
            if (w) for (int i = 0; i < int'(s); i++) ref_mem[int'(a) + i] = d[8*i +: 8];
            for (int i = 0; i < int'(s); i++) check("mem_byte", 64'(mem[int'(a) + i]), 64'(ref_mem[int'(a) + i]));
        end
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] a;
        logic [3:0]  s;
        int r;
        for (int i = 0; i < MEM; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b0;
        req_addr = 64'h10; req_wdata = 64'd0; req_size = 4'd8;

        // Outputs held quiet while reset is high, even with a request present
        @(negedge clk);
        check("rst_read_en", 64'(dm_read_enable), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_xfer_size", 64'(dm_xfer_size), 64'd8);
        check("rst_address", dm_address, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("idle_stall", 64'(stall), 64'd0);
        check("idle_enables", 64'({dm_read_enable, dm_write_enable}), 64'd0);
        check("idle_errs", 64'({range_err, misalign_err}), 64'd0);
        @(posedge clk); #1;

        // Directed scenarios
        run_req(1'b1, 64'h10, 64'h1122334455667788, 4'd8, got);
        run_req(1'b0, 64'h10, 64'd0, 4'd8, got);
        check("aligned_load_value", got, 64'h1122334455667788);
        run_req(1'b1, 64'h3F, 64'hFFFF_FFFF_AABB_CCDD, 4'd4, got);
        check("mis_store_3F", 64'(mem[16'h3F]), 64'hDD);
        check("mis_store_42", 64'(mem[16'h42]), 64'hAA);
        run_req(1'b0, 64'h3B, 64'd0, 4'd8, got);
        check("mis_load_value", got, 64'hAABBCCDD00000000);
        run_req(1'b0, 64'h3FC, 64'd0, 4'd8, got);
        run_req(1'b0, 64'h40, 64'd0, 4'd3, got);
        run_req(1'b0, 64'h3F8, 64'd0, 4'd8, got);
        run_req(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 4'd8, got);
        run_req(1'b0, 64'h21, 64'd0, 4'd2, got);
        run_req(1'b0, 64'h20, 64'd0, 4'd2, got);

        // Randomised traffic
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1:    s = 4'd1;
                2, 3:    s = 4'd2;
                4, 5:    s = 4'd4;
                8:       s = 4'($urandom_range(0, 15));
                default: s = 4'd8;
            endcase
            a = 64'($urandom_range(0, MEM + 16));
            run_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, s, got);
        end

        // Reset in the middle of a split store: only the first three bytes land
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h101;
        req_wdata = 64'h0102030405060708; req_size = 4'd8;
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("midrst_enables", 64'({dm_read_enable, dm_write_enable}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_stall", 64'(stall), 64'd0);
        check("midrst_resp", 64'(resp_valid), 64'd0);
        if (!TRAP) begin
            ref_mem[16'h101] = 8'h08; ref_mem[16'h102] = 8'h07; ref_mem[16'h103] = 8'h06;
        end
        for (int i = 16'h101; i <= 16'h108; i++) check("midrst_mem", 64'(mem[i]), 64'(ref_mem[i]));
        @(posedge clk); #1;
        run_req(1'b0, 64'h100, 64'd0, 4'd8, got);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_splitter.md
Name: mem_access_splitter

Overview:
- Memory-stage front end that sits directly upstream of the data memory in the pipelined CPU.
- Accepts one load/store request per cycle from the EX/MEM register and drives the data memory's address, enables, write data and transfer size.
- Aligned accesses pass straight through in one cycle.
- Misaligned accesses are split into a sequence of 1-byte accesses; the pipeline is stalled until the sequence completes, and read bytes are reassembled into a little-endian result.

Parameters:
- MEM_BYTES, 1024, size of the data memory in bytes; must be a power of two greater than 8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  memory-stage instruction performs an access this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address (any alignment).
- req_wdata  in  64  store data, little-endian, low req_size bytes used.
- req_size  in  4  transfer size in bytes: 1, 2, 4 or 8.
- dm_address  out  64  data memory address.
- dm_write_enable  out  1  data memory write enable.
- dm_read_enable  out  1  data memory read enable.
- dm_write_data  out  64  data memory write data.
- dm_xfer_size  out  4  data memory transfer size.
- dm_read_data  in  64  data memory read data (combinational read, same cycle).
- stall  out  1  hold the pipeline; upstream keeps req_* stable while 1.
- resp_valid  out  1  resp_rdata is valid this cycle (loads only).
- resp_rdata  out  64  load result, zero-extended above req_size bytes.
- misalign_err  out  1  misaligned request rejected (only with the optional feature).
- range_err  out  1  request rejected: req_addr + req_size > MEM_BYTES, or illegal size.

Behaviour:
- State machine: IDLE, SPLIT.
- Reset values:
  - State: IDLE; byte counter cnt = 0; latched request and assembly register = 0.
  - All outputs 0: stall, resp_valid, both errors, both dm enables, dm_address, dm_write_data. dm_xfer_size = 8.
- Legality checks (combinational, IDLE only):
  - req_size is not 1/2/4/8, or req_addr + req_size > MEM_BYTES: range_err = 1 for that cycle; no dm enable asserted; stall = 0; resp_valid = 0.
  - Misaligned means (req_addr & (req_size-1)) != 0.
- IDLE, legal aligned request (latency 0):
  - dm_* driven combinationally from req_*; dm_read_enable = ~req_write, dm_write_enable = req_write.
  - For a load, resp_valid = 1 and resp_rdata = dm_read_data masked to the low req_size bytes.
  - stall = 0; state stays IDLE.
- IDLE, legal misaligned request:
  - Drive a byte access at req_addr with dm_xfer_size = 1 and dm_write_data[7:0] = req_wdata[7:0].
  - Capture the read byte into assembly[7:0].
  - Latch addr, wdata, size and write; cnt <= 1; stall = 1; resp_valid = 0; go to SPLIT.
- SPLIT, each cycle:
  - dm_address = latched_addr + cnt; dm_xfer_size = 1; dm_write_data[7:0] = latched_wdata byte cnt.
  - For loads, the read byte is stored at assembly[8*cnt+7 -: 8].
- SPLIT, cnt < size-1: stall = 1; cnt++.
- SPLIT, cnt == size-1 (final byte):
  - stall = 0.
  - For loads, resp_valid = 1 and resp_rdata = assembly with the current byte merged combinationally.
  - cnt <= 0; go to IDLE.
- Total latency for a misaligned access of size S is S cycles; stall is high for S-1 of them.
- In SPLIT, req_* inputs are ignored; the latched copy is authoritative.
- req_valid = 0 in IDLE: no enables; all response outputs 0.
- Address arithmetic is 64-bit and unsigned. Crossing a dword boundary needs no special case because every access is a byte.
- Reset asserted mid-SPLIT: return to IDLE next edge; remaining bytes are not accessed. Bytes already stored remain in memory; no response is produced.
- All dm_* and response outputs are combinational from state plus inputs. No output is asserted in the cycle reset is high.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- When defined:
  - A misaligned legal request is not split: misalign_err = 1 for that cycle, no dm enable, stall = 0, resp_valid = 0.
  - The SPLIT state is unreachable and may be omitted.
- When undefined: misalign_err is tied to 0 and splitting operates as described above.

Test Plan:
- Aligned load: pre-store 0x1122334455667788 at 0x10, then load size 8 at 0x10 -> resp_valid same cycle, resp_rdata = 0x1122334455667788, stall = 0, one dm read of size 8.
- Misaligned store: store 0xAABBCCDD, size 4, at 0x3F (crosses a dword boundary) -> stall high 3 cycles; 4 byte writes at 0x3F..0x42. Bytes: mem[0x3F] = 0xDD, mem[0x40] = 0xCC, mem[0x41] = 0xBB, mem[0x42] = 0xAA.
- Misaligned load: load size 8 at 0x3B after the above and after 0x00 fill -> 8 byte reads; resp_valid on the 8th cycle; resp_rdata = 0x00000000AABBCCDD shifted by 4 bytes = 0xAABBCCDD00000000.
- Range/size error: load size 8 at 0x3FC -> range_err = 1, no enables. A request with size 3 -> range_err = 1.
- Reset mid-split: store size 8 at 0x101; assert reset after 3 bytes -> mem 0x101..0x103 written, 0x104..0x108 unchanged; state IDLE, stall = 0 the next cycle.
- With MEM_MISALIGN_TRAP_EN: load size 2 at 0x21 -> misalign_err = 1, stall = 0, no dm access; aligned size 2 at 0x20 still completes in 1 cycle.
